// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered binary-to-one-hot decoder with range check and self-timed scan.
module onehot_scan_decoder #(
  parameter int SEL_W    = 4,
  parameter int OUTS     = 11,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [SEL_W-1:0] sel_in,
  output logic [OUTS-1:0]  dout,
  output logic [SEL_W-1:0] idx,
  output logic             err,
  output logic             wrap
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
  state_t state_q, state_d;
  logic [OUTS-1:0] dout_q, dout_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [PW-1:0] pre_q, pre_d;
  logic err_q, err_d, wrap_q, wrap_d;
  logic last, top, in_rng;
  assign last   = pre_q == PW'(PRESCALE - 1);
  assign top    = idx_q == SEL_W'(OUTS - 1);
  assign in_rng = 32'(sel_in) < OUTS;
  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    err_d   = err_q;
    pre_d   = pre_q;
    wrap_d  = 1'b0;
    if (en) begin
      if (mode && state_q != SCAN) begin
        state_d = SCAN;
        dout_d  = OUTS'(1);
        idx_d   = '0;
        err_d   = 1'b0;
        pre_d   = '0;
      end else if (mode) begin
        pre_d = last ? '0 : pre_q + 1'b1;
        if (last) begin
          idx_d  = top ? '0 : idx_q + 1'b1;
          dout_d = top ? OUTS'(1) : dout_q << 1;
          wrap_d = top;
        end
      end else begin
        if (state_q == SCAN) begin
          state_d = DIRECT;
          pre_d   = '0;
        end
        if (load) begin
          state_d = DIRECT;
          idx_d   = sel_in;
          dout_d  = in_rng ? OUTS'(1) << sel_in : '0;
          err_d   = !in_rng;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dout_q  <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      pre_q   <= pre_d;
    end
  end
  assign dout = dout_q;
  assign idx  = idx_q;
  assign err  = err_q;
  assign wrap = wrap_q;
endmodule
